barrel_shifter: RTL and testbench

//   Parameterised single-cycle barrel shifter with a registered output.

---
 rtl/barrel_shifter.sv | 116 +++++++++++
 tb/tb_barrel_shifter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/barrel_shifter.sv
// Single-cycle barrel shifter (LSL/LSR/ASR/ROL/ROR) built from log2(WIDTH) mux stages,
// with a registered result and a one-cycle valid pipeline.
module barrel_shifter #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         data_in,
    input  logic [$clog2(WIDTH)-1:0] shift_amt,
    input  logic [2:0]               shift_type,
    output logic [WIDTH-1:0]         data_out,
    output logic                     out_valid
);

    localparam int AW = $clog2(WIDTH);

    localparam logic [2:0] OP_LSL = 3'b000;
    localparam logic [2:0] OP_LSR = 3'b001;
    localparam logic [2:0] OP_ASR = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    logic             left_s;
    logic             rotate_s;
    logic             fill_s;
    logic             bypass_s;
    logic [WIDTH-1:0] result_s;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_d;
    logic             valid_q;

    // Operation decode: direction, wrap-around, right-shift fill bit and reserved bypass.
    always_comb begin
        left_s   = 1'b0;
        rotate_s = 1'b0;
        fill_s   = 1'b0;
        bypass_s = 1'b0;
        case (shift_type)
            OP_LSL: left_s = 1'b1;
            OP_LSR: fill_s = 1'b0;
            OP_ASR: fill_s = data_in[WIDTH-1];
            OP_ROL: begin
                left_s   = 1'b1;
                rotate_s = 1'b1;
            end
            OP_ROR: rotate_s = 1'b1;
            default: bypass_s = 1'b1;
        endcase
    end

    // Stage k moves every bit by 2**k when shift_amt[k] is set; bits falling off one end
    // either wrap (rotate) or are replaced by the fill value.
    for (genvar k = 0; k < AW; k++) begin : g_stage
        localparam int D = 1 << k;
        logic [WIDTH-1:0] src_s;
        logic [WIDTH-1:0] res_s;

        if (k == 0) begin : g_first
            assign src_s = data_in;
        end else begin : g_chain
            assign src_s = g_stage[k-1].res_s;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic lbit_s;
            logic rbit_s;

            if (i >= D) begin : g_lin
                assign lbit_s = src_s[i-D];
            end else begin : g_lwrap
                assign lbit_s = rotate_s & src_s[i-D+WIDTH];
            end

            if (i + D < WIDTH) begin : g_rin
                assign rbit_s = src_s[i+D];
            end else begin : g_rwrap
                assign rbit_s = rotate_s ? src_s[i+D-WIDTH] : fill_s;
            end

            assign res_s[i] = shift_amt[k] ? (left_s ? lbit_s : rbit_s) : src_s[i];
        end
    end

    // Final result select and next-state for the output registers.
    always_comb begin
        if (bypass_s) begin
            result_s = data_in;
        end else begin
            result_s = g_stage[AW-1].res_s;
        end

        if (in_valid) begin
            data_d = result_s;
        end else begin
            data_d = data_q;
        end
        valid_d = in_valid;
    end

    // Output registers; reset clears both result and valid immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// Scoreboard bench for barrel_shifter: the driver queues expected results, a monitor
// checks every cycle's output against the queue head (or the held value when idle).
module tb_barrel_shifter;

    localparam int W  = 8;
    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  data_in;
    logic [AW-1:0] shift_amt;
    logic [2:0]    shift_type;
    logic [W-1:0]  data_out;
    logic          out_valid;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] sb_q[$];
    logic [W-1:0] hold_exp = 8'h00;

    typedef struct {
        logic [W-1:0]  d;
        logic [AW-1:0] n;
        logic [2:0]    t;
        logic [W-1:0]  e;
    } vec_t;

    barrel_shifter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .shift_amt  (shift_amt),
        .shift_type (shift_type),
        .data_out   (data_out),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int n, input logic [2:0] t);
        logic [W-1:0] r;
        case (t)
            3'd0: r = d << n;
            3'd1: r = d >> n;
            3'd2: r = W'($signed(d) >>> n);
            3'd3: r = (n == 0) ? d : ((d << n) | (d >> (W - n)));
            3'd4: r = (n == 0) ? d : ((d >> n) | (d << (W - n)));
            default: r = d;
        endcase
        return r;
    endfunction

    task automatic issue(input logic [W-1:0] d, input logic [AW-1:0] n, input logic [2:0] t,
                         input logic [W-1:0] e);
        @(negedge clk);
        data_in    = d;
        shift_amt  = n;
        shift_type = t;
        in_valid   = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            in_valid   = 1'b0;
            data_in    = 8'h5A;
            shift_amt  = 3'd1;
            shift_type = 3'd0;
        end
    endtask

    // Monitor: one result is due exactly when the queue is non-empty one edge after issue.
    always @(posedge clk) begin
        logic [W-1:0] e;
        #1;
        if (!rst_n) hold_exp = 8'h00;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("out_valid_set", 32'(out_valid), 32'd1);
            check("data_out", 32'(data_out), 32'(e));
            hold_exp = e;
        end else begin
            check("out_valid_idle", 32'(out_valid), 32'd0);
            check("data_out_held", 32'(data_out), 32'(hold_exp));
        end
    end

    vec_t vecs[$];

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        data_in    = 8'h00;
        shift_amt  = 3'd0;
        shift_type = 3'd0;
        #1;
        check("reset_data", 32'(data_out), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{8'b00001111, 3'd2, 3'b000, 8'b00111100});
        vecs.push_back('{8'b11110000, 3'd2, 3'b001, 8'b00111100});
        vecs.push_back('{8'b11110000, 3'd2, 3'b010, 8'b11111100});
        vecs.push_back('{8'b11000011, 3'd3, 3'b011, 8'b00011110});
        vecs.push_back('{8'b11000011, 3'd3, 3'b100, 8'b01111000});
        for (int t = 0; t < 8; t++) begin
            logic [2:0] tt;
            tt = 3'(t);
            vecs.push_back('{8'b10000001, 3'd0, tt, 8'b10000001});
        end
        vecs.push_back('{8'b10000001, 3'd7, 3'b000, 8'b10000000});
        vecs.push_back('{8'b10000001, 3'd7, 3'b001, 8'b00000001});
        vecs.push_back('{8'b10000001, 3'd7, 3'b010, 8'b11111111});
        vecs.push_back('{8'b10000001, 3'd7, 3'b011, 8'b11000000});
        vecs.push_back('{8'b10000001, 3'd7, 3'b100, 8'b00000011});
        vecs.push_back('{8'b10000001, 3'd3, 3'b101, 8'b10000001});
        vecs.push_back('{8'b10000001, 3'd5, 3'b110, 8'b10000001});
        vecs.push_back('{8'b10000001, 3'd6, 3'b111, 8'b10000001});
        vecs.push_back('{8'b01110000, 3'd4, 3'b010, 8'b00000111});

        // Directed vectors back-to-back, then idle cycles to exercise the hold path.
        foreach (vecs[i]) issue(vecs[i].d, vecs[i].n, vecs[i].t, vecs[i].e);
        idle(3);
        issue(8'hA5, 3'd1, 3'b001, 8'h52);
        idle(2);

        // Reset mid-stream: the op sampled while rst_n is low must never appear.
        @(negedge clk);
        data_in    = 8'hFF;
        shift_amt  = 3'd1;
        shift_type = 3'b000;
        in_valid   = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_data", 32'(data_out), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        idle(2);

        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0]  d;
            logic [AW-1:0] n;
            logic [2:0]    t;
            d = 8'($urandom);
            n = 3'($urandom_range(7, 0));
            t = 3'($urandom_range(7, 0));
            issue(d, n, t, ref_shift(d, int'(n), t));
            if ($urandom_range(9, 0) == 0) idle(1);
        end
        idle(3);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
